// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin write-port arbiter in front of an asynchronous FIFO write side.
// Requesters present words on req/req_data. A grant is taken one cycle after
// a request is seen. The owner then streams words while wfull is low. The
// grant rotates when the owner drops req or reaches the per-grant word limit.
//
// Configuration macro: WARB_BURST_EN
//   defined   -> word limit per grant is BURST_LEN
//   undefined -> word limit per grant is 1 (rotate after every word)
//
// Ports
//   wclk      : clock, all state on rising edge
//   wrst      : synchronous active-high reset
//   req       : per-requester valid
//   req_data  : requester i word in [i*DSIZE +: DSIZE]
//   ack       : per-requester "word written this cycle"
//   wfull     : FIFO full flag
//   winc      : FIFO write enable
//   wdata     : FIFO write data (owner's word)
//   gnt_vld   : a requester owns the write port
//   gnt_id    : index of the owner, valid with gnt_vld
module fifo_wr_arbiter #(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*DSIZE-1:0]         req_data,
  output logic [NREQ-1:0]               ack,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DSIZE-1:0]              wdata,
  output logic                          gnt_vld,
  output logic [$clog2(NREQ)-1:0]       gnt_id
);

  localparam int unsigned IW = $clog2(NREQ);

`ifdef WARB_BURST_EN
  localparam logic [4:0] LIMIT = 5'(BURST_LEN);
`else
  localparam logic [4:0] LIMIT = 5'd1;
`endif

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state_q,   state_d;
  logic [IW-1:0] gnt_id_q,  gnt_id_d;
  logic [IW-1:0] last_id_q, last_id_d;
  logic [4:0]    beat_q,    beat_d;

  // Round-robin search starting after last_id; last_id itself is tried last,
  // so a released owner is re-granted only when nobody else is requesting.
  logic          found;
  logic [IW-1:0] sel_id;

  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    sel_id = last_id_q;
    idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_id_q) + k) % NREQ;
      if (!found && req[idx[IW-1:0]]) begin
        found  = 1'b1;
        sel_id = idx[IW-1:0];
      end
    end
  end

  // Write-side outputs
  always_comb begin
    ack   = '0;
    wdata = '0;
    if (state_q == OWN && req[gnt_id_q] && !wfull) begin
      ack[gnt_id_q] = 1'b1;
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_id_q == IW'(i)) begin
        wdata = req_data[i*DSIZE +: DSIZE];
      end
    end
    winc    = |ack;
    gnt_vld = (state_q == OWN);
    gnt_id  = gnt_id_q;
  end

  // Next state
  always_comb begin
    logic rearb;
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    last_id_d = last_id_q;
    beat_d    = beat_q;
    rearb     = 1'b0;

    case (state_q)
      IDLE: rearb = 1'b1;
      OWN: begin
        if (winc) begin
          beat_d = beat_q + 5'd1;
        end
        // Release and re-arbitrate on the same edge, so a waiting requester
        // takes over without an idle cycle.
        if (!req[gnt_id_q] || (winc && beat_q == LIMIT - 5'd1)) begin
          rearb = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rearb) begin
      beat_d = '0;
      if (found) begin
        state_d   = OWN;
        gnt_id_d  = sel_id;
        last_id_d = sel_id;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q   <= IDLE;
      gnt_id_q  <= '0;
      last_id_q <= IW'(NREQ - 1);
      beat_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
      beat_q    <= beat_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (DSIZE=8, NREQ=4, BURST_LEN=4).
// Works for both builds; the expected words-per-grant follows WARB_BURST_EN.
module tb_fifo_wr_arbiter;

  localparam int DSIZE = 8;
  localparam int NREQ  = 4;
  localparam int BLEN  = 4;
`ifdef WARB_BURST_EN
  localparam int L = BLEN;
`else
  localparam int L = 1;
`endif

  logic                    wclk = 1'b0;
  logic                    wrst;
  logic [NREQ-1:0]         req;
  logic [NREQ*DSIZE-1:0]   req_data;
  logic [NREQ-1:0]         ack;
  logic                    wfull;
  logic                    winc;
  logic [DSIZE-1:0]        wdata;
  logic                    gnt_vld;
  logic [1:0]              gnt_id;

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST_LEN(BLEN)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .ack(ack),
    .wfull(wfull), .winc(winc), .wdata(wdata), .gnt_vld(gnt_vld), .gnt_id(gnt_id)
  );

  always #5 wclk = ~wclk;

  // Requester i presents base 0x11*(i+1) plus the count of its accepted words.
  logic [7:0] cnt [NREQ];
  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = 8'(8'h11 * (i + 1)) + cnt[i];
  end

  typedef struct {
    logic       vld;
    logic [1:0] id;
    logic       winc;
    logic [3:0] ack;
    logic [7:0] wdata;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(input logic v, input logic [1:0] id, input logic w);
    exp_t x;
    x.vld   = v;
    x.id    = id;
    x.winc  = w;
    x.ack   = w ? (4'b0001 << id) : 4'b0000;
    x.wdata = 8'(8'h11 * (id + 1)) + cnt[id];
    return x;
  endfunction

  task automatic drive(input logic [3:0] r, input logic f, input logic rs);
    req = r; wfull = f; wrst = rs;
  endtask

  task automatic do_reset();
    drive(4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < NREQ; i++) cnt[i] = 8'h00;
    @(posedge wclk); #1;
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(4'b0000, 1'b0, 1'b0);
    @(negedge wclk);
    n_cmp++; if (gnt_vld !== 1'b0) begin n_err++; $display("FAIL reset gnt_vld got %b exp 0", gnt_vld); end
    n_cmp++; if (gnt_id !== 2'd0) begin n_err++; $display("FAIL reset gnt_id got %0d exp 0", gnt_id); end
    n_cmp++; if (winc !== 1'b0) begin n_err++; $display("FAIL reset winc got %b exp 0", winc); end
    n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset ack got %b exp 0000", ack); end
    @(posedge wclk); #1;
  endtask

  // Single requester 0: grant one cycle after request, write, then back to idle.
  task automatic test_single();
    logic [3:0] rq;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      rq = (c < 2) ? 4'b0001 : 4'b0000;
      drive(rq, 1'b0, 1'b0);
      case (c)
        0: sb.push_back(mk(1'b0, 2'd0, 1'b0));
        1: sb.push_back(mk(1'b1, 2'd0, 1'b1));
        2: sb.push_back(mk(1'b1, 2'd0, 1'b0));
        default: sb.push_back(mk(1'b0, 2'd0, 1'b0));
      endcase
      @(negedge wclk);
      e = sb.pop_front();
      n_cmp++; if (gnt_vld !== e.vld) begin n_err++; $display("FAIL single c%0d gnt_vld got %b exp %b", c, gnt_vld, e.vld); end
      if (e.vld) begin n_cmp++; if (gnt_id !== e.id) begin n_err++; $display("FAIL single c%0d gnt_id got %0d exp %0d", c, gnt_id, e.id); end end
      n_cmp++; if (ack !== e.ack || winc !== e.winc) begin n_err++; $display("FAIL single c%0d ack/winc got %b/%b exp %b/%b", c, ack, winc, e.ack, e.winc); end
      if (e.winc) begin n_cmp++; if (wdata !== e.wdata) begin n_err++; $display("FAIL single c%0d wdata got %h exp %h", c, wdata, e.wdata); end end
      if (e.winc) cnt[e.id]++;
      @(posedge wclk); #1;
    end
  endtask

  // All four requesting: owners rotate 0,1,2,3,0 with L words each.
  task automatic test_rotation();
    logic [1:0] own;
    do_reset();
    for (int c = 0; c <= 5 * L + 1; c++) begin
      drive((c <= 5 * L) ? 4'b1111 : 4'b0000, 1'b0, 1'b0);
      own = 2'(((c - 1) / L) % NREQ);
      if (c == 0) sb.push_back(mk(1'b0, 2'd0, 1'b0));
      else        sb.push_back(mk(1'b1, own, c <= 5 * L));
      @(negedge wclk);
      e = sb.pop_front();
      n_cmp++; if (gnt_vld !== e.vld) begin n_err++; $display("FAIL rotation c%0d gnt_vld got %b exp %b", c, gnt_vld, e.vld); end
      if (e.vld) begin n_cmp++; if (gnt_id !== e.id) begin n_err++; $display("FAIL rotation c%0d gnt_id got %0d exp %0d", c, gnt_id, e.id); end end
      n_cmp++; if (ack !== e.ack || winc !== e.winc) begin n_err++; $display("FAIL rotation c%0d ack/winc got %b/%b exp %b/%b", c, ack, winc, e.ack, e.winc); end
      if (e.winc) begin n_cmp++; if (wdata !== e.wdata) begin n_err++; $display("FAIL rotation c%0d wdata got %h exp %h", c, wdata, e.wdata); end end
      if (e.winc) cnt[e.id]++;
      @(posedge wclk); #1;
    end
  endtask

  // Requesters 2 and 3; wfull high for 3 cycles after the first word.
  // No acks while full, grant and word count held.
  task automatic test_wfull();
    logic [1:0] own;
    int         b;
    logic       f;
    own = 2'd2; b = 0;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      f = (c >= 2 && c <= 4);
      drive(4'b1100, f, 1'b0);
      if (c == 0) sb.push_back(mk(1'b0, 2'd0, 1'b0));
      else        sb.push_back(mk(1'b1, own, !f));
      @(negedge wclk);
      e = sb.pop_front();
      n_cmp++; if (gnt_vld !== e.vld) begin n_err++; $display("FAIL wfull c%0d gnt_vld got %b exp %b", c, gnt_vld, e.vld); end
      if (e.vld) begin n_cmp++; if (gnt_id !== e.id) begin n_err++; $display("FAIL wfull c%0d gnt_id got %0d exp %0d", c, gnt_id, e.id); end end
      n_cmp++; if (ack !== e.ack || winc !== e.winc) begin n_err++; $display("FAIL wfull c%0d ack/winc got %b/%b exp %b/%b", c, ack, winc, e.ack, e.winc); end
      if (e.winc) begin n_cmp++; if (wdata !== e.wdata) begin n_err++; $display("FAIL wfull c%0d wdata got %h exp %h", c, wdata, e.wdata); end end
      if (e.winc) begin
        cnt[e.id]++;
        b++;
        if (b == L) begin b = 0; own = (own == 2'd2) ? 2'd3 : 2'd2; end
      end
      @(posedge wclk); #1;
    end
  endtask

  // Owner 1 writes 2 words then drops req as req[3] rises: handover with no
  // idle cycle, then back to IDLE once nobody requests.
  task automatic test_release();
    logic [3:0] rq;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      rq = (c <= 2) ? 4'b0010 : (c <= 4) ? 4'b1000 : 4'b0000;
      drive(rq, 1'b0, 1'b0);
      case (c)
        0:       sb.push_back(mk(1'b0, 2'd0, 1'b0));
        1, 2:    sb.push_back(mk(1'b1, 2'd1, 1'b1));
        3:       sb.push_back(mk(1'b1, 2'd1, 1'b0));
        4:       sb.push_back(mk(1'b1, 2'd3, 1'b1));
        5:       sb.push_back(mk(1'b1, 2'd3, 1'b0));
        default: sb.push_back(mk(1'b0, 2'd0, 1'b0));
      endcase
      @(negedge wclk);
      e = sb.pop_front();
      n_cmp++; if (gnt_vld !== e.vld) begin n_err++; $display("FAIL release c%0d gnt_vld got %b exp %b", c, gnt_vld, e.vld); end
      if (e.vld) begin n_cmp++; if (gnt_id !== e.id) begin n_err++; $display("FAIL release c%0d gnt_id got %0d exp %0d", c, gnt_id, e.id); end end
      n_cmp++; if (ack !== e.ack || winc !== e.winc) begin n_err++; $display("FAIL release c%0d ack/winc got %b/%b exp %b/%b", c, ack, winc, e.ack, e.winc); end
      if (e.winc) begin n_cmp++; if (wdata !== e.wdata) begin n_err++; $display("FAIL release c%0d wdata got %h exp %h", c, wdata, e.wdata); end end
      if (e.winc) cnt[e.id]++;
      @(posedge wclk); #1;
    end
  endtask

  // Reset mid-grant: next cycle idle, then requester 0 wins first.
  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      drive(4'b1111, 1'b0, c == 2);
      case (c)
        0, 3:    sb.push_back(mk(1'b0, 2'd0, 1'b0));
        1, 2:    sb.push_back(mk(1'b1, 2'(((c - 1) / L) % NREQ), 1'b1));
        default: sb.push_back(mk(1'b1, 2'd0, 1'b1));
      endcase
      @(negedge wclk);
      e = sb.pop_front();
      n_cmp++; if (gnt_vld !== e.vld) begin n_err++; $display("FAIL rst_mid c%0d gnt_vld got %b exp %b", c, gnt_vld, e.vld); end
      if (e.vld) begin n_cmp++; if (gnt_id !== e.id) begin n_err++; $display("FAIL rst_mid c%0d gnt_id got %0d exp %0d", c, gnt_id, e.id); end end
      n_cmp++; if (ack !== e.ack || winc !== e.winc) begin n_err++; $display("FAIL rst_mid c%0d ack/winc got %b/%b exp %b/%b", c, ack, winc, e.ack, e.winc); end
      if (e.winc) begin n_cmp++; if (wdata !== e.wdata) begin n_err++; $display("FAIL rst_mid c%0d wdata got %h exp %h", c, wdata, e.wdata); end end
      if (e.winc) cnt[e.id]++;
      @(posedge wclk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) cnt[i] = 8'h00;
    drive(4'b0000, 1'b0, 1'b1);
    @(posedge wclk); #1;
    test_reset();
    test_single();
    test_rotation();
    test_wfull();
    test_release();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
